// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: bus records, fetch payload, FSM states.
package fetch_unit_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [3:0] {
        NONE                   = 4'd0,
        INSTRUCTION_MISALIGNED = 4'd1
    } exception_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
        logic        is_exception;
        exception_t  exception;
    } fetch_data_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DROP,
        S_EXC
    } fetch_state_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;

    function automatic logic pc_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input iresp);
    modport slave  (input ireq, output iresp);

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Fetch PC register: reset value, redirect load, sequential advance by one instruction.
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        advance,
    output logic [63:0] pc
);

    logic [63:0] pc_d;

    // Redirect wins over sequential advance; the add wraps modulo 2^64.
    always_comb begin
        pc_d = pc;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (advance) begin
            pc_d = pc + INSTR_BYTES;
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= PC_RESET;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: one outstanding instruction-bus read, fetch payload register toward decode,
// stall/redirect handling and misaligned-PC trapping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        ibus,
    input  logic                stall,
    input  logic                redirect,
    input  logic [63:0]         redirect_pc,
    output fetch_data_t         dataF,
    output logic [63:0]         pc_o
);

    fetch_state_t state_q, state_d;
    fetch_data_t  data_q, data_d;
    logic [63:0]  pc;
    logic [63:0]  drop_addr_q, drop_addr_d;
    logic         advance;
    logic         issuing;
    logic         data_ok;
    logic         unused_addr_ok;

    assign data_ok        = ibus.iresp.data_ok;
    assign unused_addr_ok = ibus.iresp.addr_ok;

    // A request is on the bus while fetching an aligned PC or draining a dropped one.
    assign issuing = (state_q == S_REQ && !pc_misaligned(pc)) || (state_q == S_DROP);

    // Valid is gated by reset so an abandoned request disappears immediately.
    assign ibus.ireq.valid = reset && issuing;
    assign ibus.ireq.addr  = (state_q == S_DROP) ? drop_addr_q : pc;

    assign dataF = data_q;
    assign pc_o  = pc;

    fetch_unit_pc_reg #(
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .advance     (advance),
        .pc          (pc)
    );

    // Next state, PC advance and payload update; redirect flushes the payload last.
    always_comb begin
        state_d     = state_q;
        drop_addr_d = drop_addr_q;
        advance     = 1'b0;
        data_d      = data_q;
        // Without stall the current payload was taken by decode this cycle.
        if (!stall) begin
            data_d.valid = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    if (issuing && !data_ok) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc;
                    end
                end else if (pc_misaligned(pc)) begin
                    state_d = S_EXC;
                end else if (data_ok) begin
                    advance             = 1'b1;
                    data_d.raw_instr    = ibus.iresp.data;
                    data_d.pc           = pc;
                    data_d.valid        = 1'b1;
                    data_d.is_exception = 1'b0;
                    data_d.exception    = NONE;
                    state_d             = stall ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // The old response is discarded; the new PC is already in the PC register.
                if (data_ok) begin
                    state_d = S_REQ;
                end
            end
            S_EXC: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else begin
                    data_d.raw_instr    = 32'h0;
                    data_d.pc           = pc;
                    data_d.valid        = 1'b1;
                    data_d.is_exception = 1'b1;
                    data_d.exception    = INSTRUCTION_MISALIGNED;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect) begin
            data_d.valid = 1'b0;
        end
    end

    // FSM, dropped-address and payload registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_REQ;
            drop_addr_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
            data_q      <= data_d;
        end
    end

endmodule
